// File: rtl/pe_cube_sched.sv
// pe_cube_sched: sequences one pe_cube pass (clear, skewed pattern/strobe feed, drain, done).
// Ports: iClk/iRst (sync, active-high); iStart/iAbort commands; iCfgGroups/iCfgLeftShift
// latched on an accepted start; oBusy/oDone/oClearAcc status; oCfsInputPattern (3 bits per
// array), oCfsPassDataLeft, oCfsOutputLeftShift to the cube; oDataRd/oWeightRd/oWeightAddr feed.
module pe_cube_sched #(
  parameter int ARRAY_NUM = 3,
  parameter int GROUP_W = 4,
  parameter int ADDR_W = 6,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iStart,
  input  logic                     iAbort,
  input  logic [GROUP_W-1:0]       iCfgGroups,
  input  logic [4:0]               iCfgLeftShift,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oClearAcc,
  output logic [3*ARRAY_NUM-1:0]   oCfsInputPattern,
  output logic [ARRAY_NUM-2:0]     oCfsPassDataLeft,
  output logic [4:0]               oCfsOutputLeftShift,
  output logic [ARRAY_NUM-1:0]     oDataRd,
  output logic                     oWeightRd,
  output logic [ADDR_W-1:0]        oWeightAddr
);
  localparam int CW = ADDR_W + GROUP_W + 8;
  localparam logic [2:0] P1 = 3'd0, P2 = 3'd1, P3 = 3'd3, P4 = 3'd2, P5 = 3'd6;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  state_t st, ns;
  logic [CW-1:0] cnt, nc, lane_len, run_len;
  logic [GROUP_W-1:0] groups;
  logic [4:0] shift;
  logic [3*ARRAY_NUM-1:0] pat_d;
  logic [ARRAY_NUM-1:0] act, ge2;
  assign lane_len = CW'(2) + CW'(3) * CW'(groups);
  assign run_len = lane_len + CW'(ARRAY_NUM - 1);
  assign oCfsOutputLeftShift = shift;
  always_comb begin
    ns = st;
    nc = '0;
    case (st)
      IDLE:  ns = iStart ? CLEAR : IDLE;
      CLEAR: ns = RUN;
      RUN: begin
        ns = cnt == run_len - CW'(1) ? DRAIN : RUN;
        nc = cnt == run_len - CW'(1) ? '0 : cnt + CW'(1);
      end
      DRAIN: begin
        ns = cnt == CW'(DRAIN_CYCLES - 1) ? DONE : DRAIN;
        nc = cnt == CW'(DRAIN_CYCLES - 1) ? '0 : cnt + CW'(1);
      end
      default: ns = IDLE;
    endcase
    if (iAbort) ns = IDLE;
  end
  // Outputs are derived from the next state so they register in step with the FSM.
  // Lane i runs i cycles behind lane 0; k is its local step index.
  for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_lane
    logic [CW-1:0] k, m;
    assign k = nc - CW'(i);
    assign m = (k - CW'(2)) % CW'(3);
    assign act[i] = ns == RUN && nc >= CW'(i) && k < lane_len;
    assign ge2[i] = k >= CW'(2);
    assign pat_d[3*i +: 3] = !act[i] ? P3 : k == CW'(0) ? P1 : k == CW'(1) ? P2 :
                             m == CW'(0) ? P3 : m == CW'(1) ? P4 : P5;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      st <= IDLE;
      cnt <= '0;
      groups <= '0;
      shift <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oClearAcc <= 1'b0;
      oCfsInputPattern <= {ARRAY_NUM{P3}};
      oCfsPassDataLeft <= '0;
      oDataRd <= '0;
      oWeightRd <= 1'b0;
      oWeightAddr <= '0;
    end else begin
      st <= ns;
      cnt <= nc;
      if (ns == CLEAR) begin
        groups <= iCfgGroups;
        shift <= iCfgLeftShift;
      end
      oBusy <= ns != IDLE;
      oDone <= ns == DONE;
      oClearAcc <= ns == CLEAR;
      oCfsInputPattern <= pat_d;
      oCfsPassDataLeft <= act[ARRAY_NUM-1:1] & ge2[ARRAY_NUM-1:1];
      oDataRd <= act;
      oWeightRd <= ns == RUN;
      oWeightAddr <= ns == RUN ? nc[ADDR_W-1:0] : '0;
    end
  end
endmodule

// File: tb/tb_pe_cube_sched.sv
// tb_pe_cube_sched: directed table-driven bench for pe_cube_sched (ARRAY_NUM=3).
module tb_pe_cube_sched;
  logic iClk = 1'b0, iRst, iStart, iAbort;
  logic [3:0] iCfgGroups;
  logic [4:0] iCfgLeftShift;
  logic oBusy, oDone, oClearAcc, oWeightRd;
  logic [8:0] oCfsInputPattern;
  logic [1:0] oCfsPassDataLeft;
  logic [4:0] oCfsOutputLeftShift;
  logic [2:0] oDataRd;
  logic [5:0] oWeightAddr;
  int n_cmp = 0, n_bad = 0;
  typedef struct { int g; int sh; int len; int done_at; } pass_t;
  pass_t cfg [3];
  int el [3][3][13];
  int ep [3][13];
  int er [3][13];
  always #5 iClk = ~iClk;
  pe_cube_sched dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAbort(iAbort),
    .iCfgGroups(iCfgGroups), .iCfgLeftShift(iCfgLeftShift),
    .oBusy(oBusy), .oDone(oDone), .oClearAcc(oClearAcc),
    .oCfsInputPattern(oCfsInputPattern), .oCfsPassDataLeft(oCfsPassDataLeft),
    .oCfsOutputLeftShift(oCfsOutputLeftShift), .oDataRd(oDataRd),
    .oWeightRd(oWeightRd), .oWeightAddr(oWeightAddr)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge iClk);
    #1;
  endtask
  task automatic idle_chk(input string tag, input int sh);
    chk({tag, " busy"}, 32'(oBusy), 0);
    chk({tag, " done"}, 32'(oDone), 0);
    chk({tag, " clear"}, 32'(oClearAcc), 0);
    chk({tag, " pattern"}, 32'(oCfsInputPattern), 32'h0DB);
    chk({tag, " passleft"}, 32'(oCfsPassDataLeft), 0);
    chk({tag, " datard"}, 32'(oDataRd), 0);
    chk({tag, " weightrd"}, 32'(oWeightRd), 0);
    chk({tag, " weightaddr"}, 32'(oWeightAddr), 0);
    chk({tag, " shift"}, 32'(oCfsOutputLeftShift), sh);
  endtask
  task automatic start(input int g, input int sh);
    assert (2 + 3 * g + 2 <= 64) else $error("illegal config: pass length exceeds weight address space");
    iCfgGroups = 4'(g);
    iCfgLeftShift = 5'(sh);
    iStart = 1'b1;
    tick;
    iStart = 1'b0;
    chk("start clearacc", 32'(oClearAcc), 1);
    chk("start busy", 32'(oBusy), 1);
    chk("start pattern", 32'(oCfsInputPattern), 32'h0DB);
    chk("start shift", 32'(oCfsOutputLeftShift), sh);
  endtask
  initial begin
    int s;
    bit done_seen;
    cfg[0] = '{1, 5, 7, 13};
    cfg[1] = '{3, 9, 13, 19};
    cfg[2] = '{0, 17, 4, 10};
    el[0] = '{'{0,1,3,2,6,3,3,3,3,3,3,3,3}, '{3,0,1,3,2,6,3,3,3,3,3,3,3}, '{3,3,0,1,3,2,6,3,3,3,3,3,3}};
    el[1] = '{'{0,1,3,2,6,3,2,6,3,2,6,3,3}, '{3,0,1,3,2,6,3,2,6,3,2,6,3}, '{3,3,0,1,3,2,6,3,2,6,3,2,6}};
    el[2] = '{'{0,1,3,3,3,3,3,3,3,3,3,3,3}, '{3,0,1,3,3,3,3,3,3,3,3,3,3}, '{3,3,0,1,3,3,3,3,3,3,3,3,3}};
    ep[0] = '{0,0,0,1,3,3,2,0,0,0,0,0,0};
    ep[1] = '{0,0,0,1,3,3,3,3,3,3,3,3,2};
    ep[2] = '{0,0,0,0,0,0,0,0,0,0,0,0,0};
    er[0] = '{1,3,7,7,7,6,4,0,0,0,0,0,0};
    er[1] = '{1,3,7,7,7,7,7,7,7,7,7,6,4};
    er[2] = '{1,3,6,4,0,0,0,0,0,0,0,0,0};
    iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0; iCfgGroups = '0; iCfgLeftShift = '0;
    repeat (3) tick;
    idle_chk("reset", 0);
    iRst = 1'b0;
    tick;
    idle_chk("post-reset", 0);
    for (int p = 0; p < 3; p++) begin
      start(cfg[p].g, cfg[p].sh);
      for (int n = 2; n <= cfg[p].done_at; n++) begin
        tick;
        s = n - 2;
        if (s < cfg[p].len) begin
          chk($sformatf("p%0d s%0d pattern", p, s), 32'(oCfsInputPattern),
              el[p][2][s] * 64 + el[p][1][s] * 8 + el[p][0][s]);
          chk($sformatf("p%0d s%0d passleft", p, s), 32'(oCfsPassDataLeft), ep[p][s]);
          chk($sformatf("p%0d s%0d datard", p, s), 32'(oDataRd), er[p][s]);
          chk($sformatf("p%0d s%0d weightrd", p, s), 32'(oWeightRd), 1);
          chk($sformatf("p%0d s%0d weightaddr", p, s), 32'(oWeightAddr), s);
          chk($sformatf("p%0d s%0d clearacc", p, s), 32'(oClearAcc), 0);
          chk($sformatf("p%0d s%0d done", p, s), 32'(oDone), 0);
        end else begin
          chk($sformatf("p%0d n%0d pattern", p, n), 32'(oCfsInputPattern), 32'h0DB);
          chk($sformatf("p%0d n%0d datard", p, n), 32'(oDataRd), 0);
          chk($sformatf("p%0d n%0d weightrd", p, n), 32'(oWeightRd), 0);
          chk($sformatf("p%0d n%0d passleft", p, n), 32'(oCfsPassDataLeft), 0);
          chk($sformatf("p%0d n%0d done", p, n), 32'(oDone), 32'(n == cfg[p].done_at));
        end
        chk($sformatf("p%0d n%0d busy", p, n), 32'(oBusy), 1);
      end
      tick;
      idle_chk($sformatf("p%0d end", p), cfg[p].sh);
    end
    iCfgGroups = 4'd1; iCfgLeftShift = 5'd5; iStart = 1'b1;
    tick;
    chk("hold clearacc", 32'(oClearAcc), 1);
    iCfgLeftShift = 5'd7;
    for (int n = 2; n <= 13; n++) begin
      tick;
      chk($sformatf("hold n%0d clearacc", n), 32'(oClearAcc), 0);
      chk($sformatf("hold n%0d shift", n), 32'(oCfsOutputLeftShift), 5);
      chk($sformatf("hold n%0d done", n), 32'(oDone), 32'(n == 13));
    end
    tick;
    chk("first idle busy", 32'(oBusy), 0);
    chk("first idle clearacc", 32'(oClearAcc), 0);
    chk("first idle shift", 32'(oCfsOutputLeftShift), 5);
    tick;
    chk("restart clearacc", 32'(oClearAcc), 1);
    chk("restart shift", 32'(oCfsOutputLeftShift), 7);
    chk("restart busy", 32'(oBusy), 1);
    iStart = 1'b0;
    repeat (4) tick;
    chk("abort s3 pattern", 32'(oCfsInputPattern), 32'h05A);
    chk("abort s3 passleft", 32'(oCfsPassDataLeft), 1);
    iAbort = 1'b1;
    tick;
    idle_chk("abort", 7);
    iStart = 1'b1;
    tick;
    idle_chk("abort+start", 7);
    iStart = 1'b0; iAbort = 1'b0;
    done_seen = 1'b0;
    repeat (16) begin
      tick;
      done_seen |= oDone | oBusy;
    end
    chk("no done after abort", 32'(done_seen), 0);
    start(1, 9);
    repeat (3) tick;
    chk("pre-reset busy", 32'(oBusy), 1);
    iRst = 1'b1;
    tick;
    iRst = 1'b0;
    idle_chk("mid-pass reset", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pe_cube_sched.md
Name: pe_cube_sched

Overview:
Sequencer for one pe_cube pass. On a start command it clears the accumulators. It then drives the per-array input-pattern codes, skewed one cycle per array, plus the pass-data-left enables and the data/weight read strobes that feed the cube. After a fixed drain it reports completion. It sits between the layer controller (start/config) and the pe_cube configuration and feed ports.

Parameters:
ARRAY_NUM, 3, number of PE arrays in the cube; pattern and read-strobe lane count.
GROUP_W, 4, width of group-count config; max groups = 2^GROUP_W-1.
ADDR_W, 6, width of weight read address.
DRAIN_CYCLES, 4, cycles from last issued step until pe_cube results are stable.

Ports:
iClk  in  1  clock, rising edge.
iRst  in  1  reset, synchronous, active-high.
iStart  in  1  start request; sampled only in IDLE.
iAbort  in  1  abort current pass; returns to IDLE next cycle.
iCfgGroups  in  GROUP_W  number of {P3,P4,P5} groups per array (G).
iCfgLeftShift  in  5  output left shift for this pass.
oBusy  out  1  high from the cycle after start is accepted until oDone, inclusive.
oDone  out  1  one-cycle pulse; results valid.
oClearAcc  out  1  one-cycle accumulator clear.
oCfsInputPattern  out  3*ARRAY_NUM  pattern code per array; lane i = bits [3i+2:3i].
oCfsPassDataLeft  out  ARRAY_NUM-1  pass enable between array j and j+1.
oCfsOutputLeftShift  out  5  latched shift config.
oDataRd  out  ARRAY_NUM  per-array data fetch strobe.
oWeightRd  out  1  weight fetch strobe.
oWeightAddr  out  ADDR_W  weight index = current step.

Behaviour:
- Pattern codes: P1=3'd0, P2=3'd1, P3=3'd3, P4=3'd2, P5=3'd6. P3 is also the idle/hold code.
- All outputs are registered. Reset values:
  - oBusy, oDone, oClearAcc, oCfsPassDataLeft, oDataRd, oWeightRd, oWeightAddr = 0.
  - oCfsOutputLeftShift = 0.
  - every oCfsInputPattern lane = P3.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - iStart=1 at edge t → CLEAR at t+1.
  - iCfgGroups and iCfgLeftShift are latched at t; oCfsOutputLeftShift updates at t+1 and holds until the next accepted start.
- CLEAR: oClearAcc=1 for exactly this one cycle; all lanes P3 → RUN.
- RUN: step counter s = 0..L-1, with L = 2 + 3G + (ARRAY_NUM-1).
  - Per lane i, local index k = s - i. Active when 0 <= k < 2+3G.
  - Active lane code: k=0 → P1; k=1 → P2; otherwise P3/P4/P5 for (k-2) mod 3 = 0/1/2.
  - Inactive lane code: P3.
  - oDataRd[i] = lane i active.
  - oCfsPassDataLeft[j] = lane j+1 active and k >= 2.
  - oWeightRd=1 and oWeightAddr=s for all of RUN.
  - At s=L-1 → DRAIN.
- DRAIN:
  - All lanes P3; strobes 0; pass enables 0.
  - Counter runs DRAIN_CYCLES cycles → DONE.
- DONE: oDone=1 for one cycle, oBusy still 1 → IDLE.
- G=0 is legal: L = ARRAY_NUM+1, lanes issue only P1,P2, no pass enables.
- iStart outside IDLE is ignored, including in the DONE cycle. A new start is accepted in the first IDLE cycle.
- iAbort in CLEAR/RUN/DRAIN/DONE:
  - Next cycle IDLE, all strobes 0, lanes P3.
  - No oDone.
  - oCfsOutputLeftShift retained.
- iAbort and iStart together in IDLE: abort wins, start dropped.
- iRst mid-pass: next cycle all outputs at reset values, state IDLE.
- oWeightAddr is truncated to ADDR_W. Configurations with L > 2^ADDR_W are illegal; the bench asserts against them.

Test Plan:
1. Reset 3 cycles, ARRAY_NUM=3 → lanes = 3'd3 each, all strobes/done 0, oCfsOutputLeftShift=0.
2. Start, G=1, shift=5:
   - Start at t → oClearAcc at t+1 only.
   - Lane0 codes s0..s6 = 0,1,3,2,6,3,3. Lane1 = 3,0,1,3,2,6,3. Lane2 = 3,3,0,1,3,2,6.
   - PassDataLeft = 00,00,00,01,11,11,10.
   - oWeightAddr 0..6; oDone at t+2+7+4 = t+13; oCfsOutputLeftShift=5.
3. G=3 → L=13, lane2 shows P3,P4,P5 three times (s4..s12); oDone at t+19.
4. G=0 → L=4, PassDataLeft stays 00, lane0 = 0,1,3,3; oDone at t+10.
5. iStart re-asserted during RUN and DONE → ignored; start the cycle after DONE → oClearAcc one cycle later.
6. iAbort at s=3 of G=1 pass → next cycle IDLE, lanes 3'd3, no oDone; same cycle iAbort+iStart in IDLE → stays IDLE.
